// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct: rate-1/2 convolutional encoder with
// 802.11a puncturing (2/3, 3/4) and valid/ready flow control.
module conv_encoder_punct #(
   parameter int unsigned    K  = 7,
   parameter logic [K-1:0]   G0 = 7'o133,
   parameter logic [K-1:0]   G1 = 7'o171
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       en,
   input  logic       start,
   input  logic [1:0] rate,
   input  logic       data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       data_out,
   output logic       out_valid,
   input  logic       out_ready
);

   typedef enum logic [1:0] {
      R12  = 2'd0,
      R23  = 2'd1,
      R34  = 2'd2,
      RRSV = 2'd3
   } rate_t;

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2
   } phase_t;

   logic [K-2:0] r_sr;
   rate_t        r_rate;
   phase_t       r_phase;
   phase_t       w_phase_nxt;
   logic [1:0]   r_cnt;
   logic [1:0]   w_cnt_nxt;
   logic         r_buf0;
   logic         r_buf1;
   logic         w_buf0_nxt;
   logic         w_buf1_nxt;

   logic [K-1:0] w_win;
   logic         w_a;
   logic         w_b;
   logic         w_start;
   logic         w_acc;
   logic         w_pop;
   logic         w_keep_a;
   logic         w_keep_b;

   assign w_start = en & start;
   assign w_win   = {data_in, r_sr};
   assign w_a     = ^(w_win & G0);
   assign w_b     = ^(w_win & G1);

   assign out_valid = en & (r_cnt != 2'd0);
   assign data_out  = out_valid & r_buf0;

   // Room for a new bit: buffer empty, or its last bit leaves now.
   assign in_ready = en & ~start & reset &
                     ((r_cnt == 2'd0) |
                      ((r_cnt == 2'd1) & out_ready));

   assign w_acc = in_valid & in_ready;
   assign w_pop = out_valid & out_ready;

   // Puncture phase: next phase and which coded bits survive.
   always_comb begin
      w_phase_nxt = r_phase;
      w_keep_a    = 1'b1;
      w_keep_b    = 1'b1;
      unique case (r_phase)
         PH0: begin
            if (w_acc && (r_rate == R23 || r_rate == R34))
               w_phase_nxt = PH1;
         end
         PH1: begin
            w_keep_b = 1'b0;
            if (w_acc)
               w_phase_nxt = (r_rate == R34) ? PH2 : PH0;
         end
         PH2: begin
            w_keep_a = 1'b0;
            if (w_acc)
               w_phase_nxt = PH0;
         end
         default: begin
            w_phase_nxt = PH0;
         end
      endcase
      if (w_start)
         w_phase_nxt = PH0;
   end

   // Output buffer: pop first, then push the kept bits (A before B).
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_buf0_nxt = r_buf0;
      w_buf1_nxt = r_buf1;
      if (w_pop) begin
         w_buf0_nxt = r_buf1;
         w_cnt_nxt  = r_cnt - 2'd1;
      end
      if (w_acc) begin
         // in_ready guarantees the buffer is empty after the pop.
         w_buf0_nxt = w_keep_a ? w_a : w_b;
         w_buf1_nxt = w_b;
         w_cnt_nxt  = (w_keep_a & w_keep_b) ? 2'd2 : 2'd1;
      end
      if (w_start) begin
         w_cnt_nxt  = 2'd0;
         w_buf0_nxt = 1'b0;
         w_buf1_nxt = 1'b0;
      end
   end

   // Phase state register.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         r_phase <= PH0;
      else if (en)
         r_phase <= w_phase_nxt;
   end

   // Buffer state register.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= 2'd0;
         r_buf0 <= 1'b0;
         r_buf1 <= 1'b0;
      end else if (en) begin
         r_cnt  <= w_cnt_nxt;
         r_buf0 <= w_buf0_nxt;
         r_buf1 <= w_buf1_nxt;
      end
   end

   // Encoder shift register: cleared per packet, shifts on accept.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         r_sr <= '0;
      else if (w_start)
         r_sr <= '0;
      else if (w_acc)
         r_sr <= w_win[K-1:1];
   end

   // Rate latched once per packet.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         r_rate <= R12;
      else if (w_start)
         r_rate <= rate_t'(rate);
   end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// tb_conv_encoder_punct: random and directed stimulus checked
// every cycle against a convolution/puncture reference model.
module tb_conv_encoder_punct;

   localparam int K = 7;
   localparam logic [6:0] G0 = 7'o133;
   localparam logic [6:0] G1 = 7'o171;

   logic       Clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       start = 1'b0;
   logic [1:0] rate = 2'd0;
   logic       data_in = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       data_out;
   logic       out_valid;

   int checks = 0;
   int failures = 0;

   bit exp_q[$];
   bit hist[$];
   bit obs[$];
   bit mlog[$];
   int n_acc = 0;
   int lrate = 0;
   bit done;

   conv_encoder_punct #(
      .K (K),
      .G0(G0),
      .G1(G1)
   ) dut (
      .Clk      (Clk),
      .reset    (reset),
      .en       (en),
      .start    (start),
      .rate     (rate),
      .data_in  (data_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .data_out (data_out),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_seq(input string name, input bit q[$],
                          input logic [31:0] val, input int len);
      logic [31:0] v;
      v = '0;
      foreach (q[i]) v = {v[30:0], q[i]};
      checks++;
      if (q.size() != len || v !== val) begin
         failures++;
         $display("FAIL %s: got %0d bits 0x%0h expected %0d bits 0x%0h",
                  name, q.size(), v, len, val);
      end
   endtask

   // Coded bit as a convolution over the input history.
   function automatic bit coded(input bit din, input logic [6:0] g);
      bit acc;
      bit b;
      acc = 1'b0;
      for (int j = 0; j < K; j++) begin
         if (j == 0) b = din;
         else if (hist.size() >= j) b = hist[hist.size() - j];
         else b = 1'b0;
         acc ^= b & g[K-1-j];
      end
      return acc;
   endfunction

   task automatic model_push(input bit din);
      bit a;
      bit b;
      int ph;
      a = coded(din, G0);
      b = coded(din, G1);
      case (lrate)
         1: ph = n_acc % 2;
         2: ph = n_acc % 3;
         default: ph = 0;
      endcase
      if (ph != 2) exp_q.push_back(a);
      if (ph != 1) exp_q.push_back(b);
      hist.push_back(din);
      while (hist.size() > K) void'(hist.pop_front());
      n_acc++;
   endtask

   task automatic model_clear();
      exp_q.delete();
      hist.delete();
      n_acc = 0;
   endtask

   // Per-cycle compare; model advances for the coming edge.
   always @(negedge Clk) begin
      bit ev;
      bit ei;
      if (!reset) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         model_clear();
         lrate = 0;
      end else if (!en) begin
         chk("en0_out_valid", out_valid, 0);
         chk("en0_in_ready", in_ready, 0);
         chk("en0_data_out", data_out, 0);
      end else begin
         ev = (exp_q.size() != 0);
         ei = !start && (exp_q.size() == 0 ||
                         (exp_q.size() == 1 && out_ready));
         chk("out_valid", out_valid, ev);
         if (ev) chk("data_out", data_out, exp_q[0]);
         chk("in_ready", in_ready, ei);
         if (start) begin
            model_clear();
            lrate = rate;
         end else begin
            if (ev && out_ready) begin
               obs.push_back(data_out);
               mlog.push_back(exp_q[0]);
               void'(exp_q.pop_front());
            end
            if (ei && in_valid) model_push(data_in);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr_logs();
      obs.delete();
      mlog.delete();
   endtask

   task automatic do_start(input logic [1:0] r);
      start = 1'b1;
      rate = r;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input bit b);
      int n;
      bit took;
      n = 0;
      took = 1'b0;
      data_in = b;
      in_valid = 1'b1;
      while (!took && n < 200) begin
         @(negedge Clk);
         took = in_ready;
         tick();
         n++;
      end
      if (!took) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got 0 accepts expected 1");
      end
   endtask

   task automatic send_seq(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send(v[i]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int explen;
      tick();
      tick();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_data_out", data_out, 0);
      chk("reset_in_ready", in_ready, 0);
      reset = 1'b1;
      en = 1'b1;
      out_ready = 1'b1;
      tick();

      // impulse at rate 1/2
      do_start(2'd0);
      clr_logs();
      send_seq(32'b1000000, 7);
      drain();
      chk_seq("impulse", obs, 32'b11011111001011, 14);
      chk_seq("impulse_model", mlog, 32'b11011111001011, 14);

      // rate 2/3
      do_start(2'd1);
      clr_logs();
      send_seq(32'b1000, 4);
      drain();
      chk_seq("rate23", obs, 32'b110111, 6);
      chk_seq("rate23_model", mlog, 32'b110111, 6);

      // rate 3/4, then rate change without start
      do_start(2'd2);
      clr_logs();
      send_seq(32'b100, 3);
      drain();
      chk_seq("rate34", obs, 32'b1101, 4);
      chk_seq("rate34_model", mlog, 32'b1101, 4);
      rate = 2'd0;
      clr_logs();
      send_seq(32'b100, 3);
      drain();
      chk_seq("rate34_held", obs, 32'b0001, 4);
      chk_seq("rate34_held_model", mlog, 32'b0001, 4);

      // reserved rate behaves as 1/2
      do_start(2'd3);
      clr_logs();
      send_seq(32'b100, 3);
      drain();
      chk_seq("rate_rsv", obs, 32'b110111, 6);

      // back-pressure mid-stream
      do_start(2'd0);
      clr_logs();
      fork
         begin
            for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)));
         end
         begin
            repeat (4) tick();
            out_ready = 1'b0;
            repeat (3) tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            repeat (2) tick();
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_len", obs.size(), 40);

      // start while the buffer is full
      do_start(2'd0);
      clr_logs();
      out_ready = 1'b0;
      send(1'b1);
      in_valid = 1'b0;
      tick();
      chk("full_out_valid", out_valid, 1);
      do_start(2'd0);
      chk("start_clears", out_valid, 0);
      clr_logs();
      out_ready = 1'b1;
      send(1'b1);
      drain();
      chk_seq("start_sr_clear", obs, 32'b11, 2);

      // start with in_valid: input not consumed
      data_in = 1'b1;
      in_valid = 1'b1;
      do_start(2'd0);
      in_valid = 1'b0;
      chk("start_no_accept", out_valid, 0);
      clr_logs();
      send_seq(32'b00, 2);
      drain();
      chk_seq("start_no_accept_seq", obs, 32'b0000, 4);

      // async reset mid-packet
      do_start(2'd1);
      clr_logs();
      out_ready = 1'b0;
      send(1'b1);
      in_valid = 1'b0;
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_in_ready", in_ready, 0);
      tick();
      tick();
      reset = 1'b1;
      out_ready = 1'b1;
      clr_logs();
      send_seq(32'b1000000, 7);
      drain();
      chk_seq("post_reset_impulse", obs, 32'b11011111001011, 14);

      // enable low for 3 cycles mid-stream
      do_start(2'd2);
      clr_logs();
      fork
         begin
            for (int i = 0; i < 12; i++) send(1'($urandom_range(0, 1)));
         end
         begin
            repeat (3) tick();
            en = 1'b0;
            #1;
            chk("en0_now_valid", out_valid, 0);
            chk("en0_now_ready", in_ready, 0);
            repeat (3) tick();
            en = 1'b1;
         end
      join
      drain();
      chk("en_len", obs.size(), 16);

      // random traffic at every rate
      for (int r = 0; r < 4; r++) begin
         do_start(r[1:0]);
         clr_logs();
         done = 1'b0;
         fork
            begin
               for (int i = 0; i < 60; i++) begin
                  send(1'($urandom_range(0, 1)));
                  if ($urandom_range(0, 3) == 0) begin
                     in_valid = 1'b0;
                     tick();
                  end
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  out_ready = 1'($urandom_range(0, 1));
                  tick();
               end
            end
         join
         drain();
         explen = (r == 1) ? 90 : (r == 2) ? 80 : 120;
         chk("rand_len", obs.size(), explen);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
